// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR generator slice.
//
// Contents:
//   IDLE, RUN      - FSM state encoding used by lfsr_gen
//   TAPS_W*        - known maximal-length Fibonacci tap masks for common widths
//   default_taps() - picks a tap mask for a given register width
package lfsr_pkg;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [3:0]  TAPS_W4  = 4'b1100;
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [31:0] TAPS_W32 = 32'h80200003;

    // Widths without a table entry fall back to tapping the two top bits.
    // That keeps the register invertible but is not guaranteed maximal.
    function automatic logic [31:0] default_taps(input int width);
        case (width)
            4:       return 32'(TAPS_W4);
            8:       return 32'(TAPS_W8);
            16:      return 32'(TAPS_W16);
            32:      return TAPS_W32;
            default: return (32'd1 << (width - 1)) | (32'd1 << (width - 2));
        endcase
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational Fibonacci LFSR next-state function.
//
// Parameters:
//   WIDTH - register width (2..32)
//   TAPS  - feedback mask, bit i set means state[i] feeds the XOR
// Ports:
//   state - current register value
//   next  - value after one shift: {state[WIDTH-2:0], feedback}
module lfsr_step #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8)
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next
);

    logic fb;

    assign fb   = ^(state & TAPS);
    assign next = {state[WIDTH-2:0], fb};

endmodule

// File: rtl/lfsr_gen.sv
// LFSR sequence generator with seed load and period measurement.
//
// Parameters:
//   WIDTH - register width (2..32)
//   TAPS  - feedback mask (defaults to the package table entry for WIDTH)
//   SEED  - state after reset, and the replacement for an all-zero load
// Ports:
//   clk          - rising-edge clock
//   rst_n        - synchronous active-low reset
//   en           - step enable (steps only while the FSM is in RUN)
//   load         - seed load strobe, wins over en
//   seed         - value captured on load
//   out          - serial output, MSB of the register
//   state        - current register value
//   busy         - FSM is in RUN
//   wrap         - one-cycle pulse when the register returns to the reference
//   period       - step count of the first full cycle after the reference
//   period_valid - period holds a measurement; cleared by load or reset
//   zero_fix     - one-cycle pulse when a zero seed was replaced by SEED
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic             out,
    output logic [WIDTH-1:0] state,
    output logic             busy,
    output logic             wrap,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             zero_fix
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [0:0]       fsm_state;
    logic [WIDTH-1:0] next_state;
    logic [WIDTH-1:0] reference;
    logic [WIDTH-1:0] step_cnt;
    logic [WIDTH-1:0] load_val;
    logic             do_step;
    logic             hit_ref;

    lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .state (state),
        .next  (next_state)
    );

    // The cycle that enters RUN never steps, because do_step looks at the
    // registered FSM state rather than the one being entered.
    assign do_step  = (fsm_state == RUN) && en && !load;
    assign hit_ref  = do_step && (next_state == reference);
    assign load_val = (seed == '0) ? SEED : seed;

    assign out  = state[WIDTH-1];
    assign busy = (fsm_state == RUN);

    // FSM: load always drops back to IDLE; otherwise en alone decides
    // whether we sit in RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_state <= IDLE;
        end else if (load) begin
            fsm_state <= IDLE;
        end else begin
            case (fsm_state)
                IDLE:    fsm_state <= en ? RUN : IDLE;
                RUN:     fsm_state <= en ? RUN : IDLE;
                default: fsm_state <= IDLE;
            endcase
        end
    end

    // Register, reference and zero-seed pulse. The reference is whatever
    // value the sequence started from, so wraps are measured against it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= SEED;
            reference <= SEED;
            zero_fix  <= 1'b0;
        end else begin
            zero_fix <= 1'b0;
            if (load) begin
                state     <= load_val;
                reference <= load_val;
                zero_fix  <= (seed == '0);
            end else if (do_step) begin
                state <= next_state;
            end
        end
    end

    // Step counter and period measurement. Only the first wrap after a
    // load/reset records the period; later wraps just pulse and restart the
    // counter. The counter saturates so a sequence that never returns to
    // the reference leaves period_valid low instead of aliasing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_cnt     <= '0;
            wrap         <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                step_cnt     <= '0;
                period_valid <= 1'b0;
            end else if (hit_ref) begin
                wrap     <= 1'b1;
                step_cnt <= '0;
                if (!period_valid) begin
                    period       <= (step_cnt == CNT_MAX) ? CNT_MAX : step_cnt + ONE;
                    period_valid <= 1'b1;
                end
            end else if (do_step && (step_cnt != CNT_MAX)) begin
                step_cnt <= step_cnt + ONE;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen.
//
// Main DUT: WIDTH=4, TAPS=4'b1100 (maximal, period 15).
// Second DUT: WIDTH=4, TAPS=4'b0001. The mask 4'b1001 is also maximal for
// this shift direction, so it would wrap at 15; 4'b0001 locks up at 1111 and
// never returns to the seed, which is what drives the counter into
// saturation with period_valid held low.
//
// Stimulus pushes one expected-output record per clock; a monitor pops and
// compares one record each cycle just after the rising edge.
module tb_lfsr_gen;

    typedef struct {
        string      tag;
        logic [3:0] state;
        logic       busy;
        logic       wrap;
        logic       pv;
        logic       zf;
        logic [3:0] period;
        bit         chk_period;
        bit         chk_nm;
        logic [3:0] nm_state;
        bit         nm_sat;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       load;
    logic [3:0] seed;

    logic       out;
    logic [3:0] state;
    logic       busy;
    logic       wrap;
    logic [3:0] period;
    logic       period_valid;
    logic       zero_fix;

    logic       nm_out;
    logic [3:0] nm_state;
    logic       nm_busy;
    logic       nm_wrap;
    logic [3:0] nm_period;
    logic       nm_period_valid;
    logic       nm_zero_fix;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Hand-computed sequence for TAPS=4'b1100 starting at 0001.
    logic [3:0] seq [0:15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                               4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};

    lfsr_gen #(
        .WIDTH (4),
        .TAPS  (4'b1100),
        .SEED  (4'b0001)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .load         (load),
        .seed         (seed),
        .out          (out),
        .state        (state),
        .busy         (busy),
        .wrap         (wrap),
        .period       (period),
        .period_valid (period_valid),
        .zero_fix     (zero_fix)
    );

    lfsr_gen #(
        .WIDTH (4),
        .TAPS  (4'b0001),
        .SEED  (4'b0001)
    ) dut_nm (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .load         (load),
        .seed         (seed),
        .out          (nm_out),
        .state        (nm_state),
        .busy         (nm_busy),
        .wrap         (nm_wrap),
        .period       (nm_period),
        .period_valid (nm_period_valid),
        .zero_fix     (nm_zero_fix)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(string tag, logic [3:0] st, logic b, logic w,
                                logic pv, logic zf);
        exp_t e;
        e.tag        = tag;
        e.state      = st;
        e.busy       = b;
        e.wrap       = w;
        e.pv         = pv;
        e.zf         = zf;
        e.period     = 4'h0;
        e.chk_period = 1'b0;
        e.chk_nm     = 1'b0;
        e.nm_state   = 4'h0;
        e.nm_sat     = 1'b0;
        return e;
    endfunction

    function automatic exp_t mkp(string tag, logic [3:0] st, logic b, logic w,
                                 logic pv, logic zf, logic [3:0] per);
        exp_t e;
        e            = mk(tag, st, b, w, pv, zf);
        e.period     = per;
        e.chk_period = 1'b1;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [3:0] act,
                               input logic [3:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic l, input logic e,
                                 input logic [3:0] sd, input exp_t x);
        @(negedge clk);
        rst_n = r;
        load  = l;
        en    = e;
        seed  = sd;
        exp_q.push_back(x);
        @(posedge clk);
    endtask

    // Monitor: one record per clock, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput({e.tag, ".state"}, state, e.state);
                checkOutput({e.tag, ".out"}, 4'(out), 4'(e.state[3]));
                checkOutput({e.tag, ".busy"}, 4'(busy), 4'(e.busy));
                checkOutput({e.tag, ".wrap"}, 4'(wrap), 4'(e.wrap));
                checkOutput({e.tag, ".period_valid"}, 4'(period_valid), 4'(e.pv));
                checkOutput({e.tag, ".zero_fix"}, 4'(zero_fix), 4'(e.zf));
                if (e.chk_period)
                    checkOutput({e.tag, ".period"}, period, e.period);
                if (e.chk_nm) begin
                    checkOutput({e.tag, ".nm_state"}, nm_state, e.nm_state);
                    checkOutput({e.tag, ".nm_period_valid"}, 4'(nm_period_valid), 4'h0);
                    checkOutput({e.tag, ".nm_wrap"}, 4'(nm_wrap), 4'h0);
                    if (e.nm_sat)
                        checkOutput({e.tag, ".nm_step_cnt"}, dut_nm.step_cnt, 4'hF);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        exp_t e;
        int   idx;
        rst_n = 1'b0;
        load  = 1'b0;
        en    = 1'b0;
        seed  = 4'h0;

        // Reset, then a full lap from the reset seed.
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, mkp("reset", 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0));
        applyStimulus(1'b1, 1'b0, 1'b1, 4'h0, mkp("entry", 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0));
        for (int k = 1; k <= 15; k++)
            applyStimulus(1'b1, 1'b0, 1'b1, 4'h0,
                mkp($sformatf("lap1_%0d", k), seq[k], 1'b1, k == 15, k == 15, 1'b0,
                    (k == 15) ? 4'd15 : 4'd0));

        // Second lap: wrap pulses again, period unchanged.
        for (int k = 1; k <= 15; k++)
            applyStimulus(1'b1, 1'b0, 1'b1, 4'h0,
                mkp($sformatf("lap2_%0d", k), seq[k], 1'b1, k == 15, 1'b1, 1'b0, 4'd15));

        // Zero seed load is replaced by SEED and flagged.
        applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, mk("zload", 4'h1, 1'b0, 1'b0, 1'b0, 1'b1));
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, mk("zload_idle", 4'h1, 1'b0, 1'b0, 1'b0, 1'b0));

        // Five steps, three-cycle pause, resume to the wrap.
        applyStimulus(1'b1, 1'b0, 1'b1, 4'h0, mk("p_entry", 4'h1, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int k = 1; k <= 5; k++)
            applyStimulus(1'b1, 1'b0, 1'b1, 4'h0,
                mk($sformatf("p_run_%0d", k), seq[k], 1'b1, 1'b0, 1'b0, 1'b0));
        for (int k = 1; k <= 3; k++)
            applyStimulus(1'b1, 1'b0, 1'b0, 4'h0,
                mk($sformatf("pause_%0d", k), 4'h6, 1'b0, 1'b0, 1'b0, 1'b0));
        applyStimulus(1'b1, 1'b0, 1'b1, 4'h0, mk("resume", 4'h6, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int k = 6; k <= 14; k++)
            applyStimulus(1'b1, 1'b0, 1'b1, 4'h0,
                mk($sformatf("p_cont_%0d", k), seq[k], 1'b1, 1'b0, 1'b0, 1'b0));
        applyStimulus(1'b1, 1'b0, 1'b1, 4'h0,
            mkp("p_wrap", 4'h1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd15));

        // load and en together: load wins, no step, FSM to IDLE.
        applyStimulus(1'b1, 1'b1, 1'b1, 4'hA, mk("ld_en", 4'hA, 1'b0, 1'b0, 1'b0, 1'b0));
        applyStimulus(1'b1, 1'b0, 1'b1, 4'h0, mk("ld_entry", 4'hA, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int k = 1; k <= 15; k++) begin
            idx = ((6 + k) % 15) + 1;
            if (k == 15)
                e = mkp("ld_wrap", seq[idx], 1'b1, 1'b1, 1'b1, 1'b0, 4'd15);
            else
                e = mk($sformatf("ld_run_%0d", k), seq[idx], 1'b1, 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b1, 1'b0, 1'b1, 4'h0, e);
        end
        for (int k = 1; k <= 2; k++)
            applyStimulus(1'b1, 1'b0, 1'b1, 4'h0,
                mkp($sformatf("ld_more_%0d", k), seq[7 + k], 1'b1, 1'b0, 1'b1, 1'b0, 4'd15));

        // Reset mid-RUN with load and en high: reset wins in one edge.
        applyStimulus(1'b0, 1'b1, 1'b1, 4'h0, mkp("rst_run", 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0));
        e = mkp("post_entry", 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        e.chk_nm   = 1'b1;
        e.nm_state = 4'h1;
        applyStimulus(1'b1, 1'b0, 1'b1, 4'h0, e);
        for (int k = 1; k <= 20; k++) begin
            idx = ((k - 1) % 15) + 1;
            e = mkp($sformatf("post_%0d", k), seq[idx], 1'b1, k == 15, k >= 15, 1'b0,
                    (k >= 15) ? 4'd15 : 4'd0);
            e.chk_nm   = 1'b1;
            e.nm_state = (k == 1) ? 4'h3 : (k == 2) ? 4'h7 : 4'hF;
            e.nm_sat   = (k >= 16);
            applyStimulus(1'b1, 1'b0, 1'b1, 4'h0, e);
        end

        @(negedge clk);
        checkOutput("queue_drained", 4'(exp_q.size()), 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
